// File: rtl/dice_pkg.sv
// Shared types and defaults for the dice roller / result scorer pair.
package dice_pkg;

    localparam int DICE_MAX_DEFAULT = 6;
    localparam int NUM_DICE_DEFAULT = 2;
    localparam int ROLL_COUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SETTLE,
        CAPTURE_ACC,
        DONE
    } scorer_state_t;

endpackage

// File: rtl/dice_button_edge.sv
// Registers a synchronous button and produces single-cycle rise/fall pulses.
module dice_button_edge (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic rise,
    output logic fall
);

    logic btn_q;

    // btn_q clears on reset, so a button already held out of reset reads as a rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) btn_q <= 1'b0;
        else        btn_q <= button;
    end

    assign rise = button & ~btn_q;
    assign fall = ~button & btn_q;

endmodule

// File: rtl/dice_result_scorer.sv
// Waits for button release plus a settle delay, snapshots the dice bus and
// scores it one die per cycle, then strobes sum / equality / range flags.
module dice_result_scorer
    import dice_pkg::*;
#(
    parameter int DICE_MAX      = DICE_MAX_DEFAULT,
    parameter int BIT_WIDTH     = $clog2(DICE_MAX) + 1,
    parameter int NUM_DICE      = NUM_DICE_DEFAULT,
    parameter int SETTLE_CYCLES = 2,
    parameter int SUM_WIDTH     = $clog2(NUM_DICE * (2**BIT_WIDTH - 1) + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          button,
    input  logic [NUM_DICE*BIT_WIDTH-1:0] dice_values,
    output logic                          result_valid,
    output logic [SUM_WIDTH-1:0]          dice_sum,
    output logic                          all_equal,
    output logic                          range_error,
    output logic [ROLL_COUNT_WIDTH-1:0]   roll_count,
    output logic                          busy
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IDX_W = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;

    scorer_state_t state, state_d;

    logic                          rise, fall;
    logic [CNT_W-1:0]              settle_cnt;
    logic [IDX_W-1:0]              idx;
    logic [NUM_DICE*BIT_WIDTH-1:0] shadow;
    logic [SUM_WIDTH-1:0]          acc, acc_next;
    logic                          eq, eq_next, err, err_next;
    logic [BIT_WIDTH-1:0]          cur_die, first_die;
    logic                          start_settle, capture, step, finish;

    dice_button_edge u_edge (
        .clk    (clk),
        .reset  (reset),
        .button (button),
        .rise   (rise),
        .fall   (fall)
    );

    assign cur_die   = shadow[idx*BIT_WIDTH +: BIT_WIDTH];
    assign first_die = shadow[BIT_WIDTH-1:0];
    assign acc_next  = acc + SUM_WIDTH'(cur_die);
    assign eq_next   = eq & (cur_die == first_die);
    assign err_next  = err | (cur_die == '0) | (cur_die > BIT_WIDTH'(DICE_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d      = state;
        start_settle = 1'b0;
        capture      = 1'b0;
        step         = 1'b0;
        finish       = 1'b0;
        case (state)
            IDLE:   if (rise) state_d = ARMED;
            ARMED:  if (fall) begin
                state_d      = SETTLE;
                start_settle = 1'b1;
            end
            SETTLE: begin
                if (rise) begin
                    state_d = ARMED;
                end else if (settle_cnt == '0) begin
                    state_d = CAPTURE_ACC;
                    capture = 1'b1;
                end
            end
            CAPTURE_ACC: begin
                step = 1'b1;
                if (idx == IDX_W'(NUM_DICE - 1)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_cnt   <= '0;
            idx          <= '0;
            shadow       <= '0;
            acc          <= '0;
            eq           <= 1'b0;
            err          <= 1'b0;
            result_valid <= 1'b0;
            dice_sum     <= '0;
            all_equal    <= 1'b0;
            range_error  <= 1'b0;
            roll_count   <= '0;
            busy         <= 1'b0;
        end else begin
            result_valid <= finish;
            busy         <= (state_d == SETTLE) || (state_d == CAPTURE_ACC) || (state_d == DONE);
            if (start_settle) begin
                settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
            end else if (state == SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            if (capture) begin
                shadow <= dice_values;
                idx    <= '0;
                acc    <= '0;
                eq     <= 1'b1;
                err    <= 1'b0;
            end else if (step) begin
                idx <= idx + 1'b1;
                acc <= acc_next;
                eq  <= eq_next;
                err <= err_next;
            end
            // Result uses the folded-in last die, not the registered accumulators.
            if (finish) begin
                dice_sum    <= acc_next;
                all_equal   <= eq_next;
                range_error <= err_next;
                roll_count  <= roll_count + 1'b1;
            end
        end
    end

endmodule
